alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Iterative 64-bit multiply controller that borrows the shared 64-bit ALU to compute MUL (low 64 bits of the product) by shift-and-add.
- Sits beside the execute stage.
- While `alu_req` is high, the top level muxes this block's `alu_a`/`alu_b`/`alu_ctrl` onto the ALU inputs and stalls the core.
- The ALU result feeds back through `alu_result`.

## Interface
Parameters:
- `WIDTH`, 64, operand/product width
- `CNT_W`, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE or DONE
- `op_a`  in  WIDTH  multiplicand; captured on accepted start
- `op_b`  in  WIDTH  multiplier; captured on accepted start
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse in DONE
- `product`  out  WIDTH  result register; holds until the next accepted start completes
- `alu_req`  out  1  equals `busy`; top-level ALU input-mux select
- `alu_a`  out  WIDTH  driven from the accumulator register
- `alu_b`  out  WIDTH  multiplicand register if multiplier bit 0 is 1, else 0
- `alu_ctrl`  out  4  constant ADD code 4'b0010
- `alu_result`  in  WIDTH  combinational ALU result, consumed in the same cycle

## Operation
- States: IDLE, RUN, DONE; encoding from the package.
- Registers: `acc`, `mcand`, `mplier` (all WIDTH wide); `cnt` (CNT_W wide).
- IDLE/DONE with `start`=1:
  - acc←0, mcand←op_a, mplier←op_b, cnt←0.
  - Next state RUN.
  - `product` is not cleared.
- IDLE/DONE with `start`=0: DONE→IDLE, IDLE→IDLE.
- RUN, every cycle:
  - acc←alu_result (acc + mcand or acc + 0).
  - mcand←mcand<<1, with bits shifted past WIDTH discarded.
  - mplier←mplier>>1, zero-filled.
  - cnt←cnt+1.
- RUN exit: when cnt==WIDTH-1 at the clock edge, product←alu_result and next state DONE.
- Arithmetic is modulo 2^WIDTH; carries out of the ALU are ignored. The low 64 bits are identical for signed and unsigned operands, so there is no sign handling.
- `start` in RUN is ignored, not queued.
- `reset` mid-RUN aborts the operation: all registers return to reset values and no `done` pulse is issued.

## Timing
- Reset values: state IDLE; busy=0, done=0, alu_req=0, product=0, acc=mcand=mplier=0, cnt=0. `alu_ctrl` is always 4'b0010.
- `busy`, `done` and `alu_req` are decoded from the state register only, with no combinational path from `start`.
- `alu_a` and `alu_b` are combinational from registers. `alu_b` depends on mplier[0].
- Latency:
  - `start` accepted at edge E.
  - RUN occupies the cycles after edges E … E+WIDTH-1.
  - `done`=1 and `product` valid in the cycle after edge E+WIDTH.
  - Default: 64 RUN cycles, and done is seen 65 cycles after start.
- Back-to-back: `start` asserted during DONE is accepted. In that case RUN begins immediately and `done` lasts exactly one cycle.

## Configuration
- Macro: `MUL_EARLY_EXIT_EN`.
- Defined: RUN also exits to DONE when the next `mplier` value (mplier>>1) is zero. `product` captures `alu_result` in that cycle, and latency becomes position-of-highest-set-bit(op_b)+1 RUN cycles.
- op_b=0 with the macro defined: still exactly one RUN cycle; product=0.
- Not defined: always WIDTH RUN cycles. The early-exit comparator is absent from the netlist.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum with AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, PASSB=4'b0111.
  - `mul_state_t` enum (IDLE, RUN, DONE).
  - `localparam` WIDTH default.
- The block imports `alu_pkg` and drives `alu_ctrl` with ADD.
- No sub-module: one FSM `always_ff`, one datapath `always_ff`, one `always_comb` for ALU drive.
- The bench instantiates the real ALU and the top-level mux.

## Test plan
- op_a=3, op_b=5, start one cycle → busy for 64 cycles; done pulse 65 cycles after start; product=15. With the macro: 3 RUN cycles.
- op_a=2^63, op_b=2 → product=0 (overflow discarded). op_a=all-ones, op_b=all-ones → product=1.
- `start` re-asserted mid-RUN with new operands → ignored; first result unchanged; done fires once.
- `reset` asserted at RUN cycle 30 → busy=0 and alu_req=0 immediately (async); product=0; no done. A following start computes correctly.
- `start` held high through DONE with op_a=7, op_b=6 after a 15 result → done one cycle; second done shows product=42.
- Macro defined: op_b=1 → done 2 cycles after the start edge, product=op_a. op_b=0 → product=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, multiply-sequencer state encoding and default datapath width.
// Imported by the ALU and by the iterative multiply controller.
package alu_pkg;

  localparam int MUL_WIDTH = 64;

  typedef enum logic [3:0] {
    AND   = 4'b0000,
    OR    = 4'b0001,
    ADD   = 4'b0010,
    SUB   = 4'b0110,
    PASSB = 4'b0111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational execute-stage ALU; zero latency, no flow control.
// Unknown opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op_t'(ctrl))
      AND:     result = a & b;
      OR:      result = a | b;
      ADD:     result = a + b;
      SUB:     result = a - b;
      PASSB:   result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL (low WIDTH bits) on the borrowed shared ALU; WIDTH RUN cycles, done one cycle later.
// start is ignored while busy; MUL_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_iter;

  // Outputs decode the state register only, so start never reaches them combinationally.
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign alu_req = busy;
  assign product = product_q;

  always_comb begin
    alu_ctrl = ADD;
    alu_a    = acc_q;
    alu_b    = mplier_q[0] ? mcand_q : '0;
  end

  always_comb begin
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
    last_iter = last_iter || ((mplier_q >> 1) == '0);
`endif
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          product_d = alu_result;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with the real ALU and top-level operand mux; results and
// latencies come from plain multiplication and the multiplier's bit position.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, alu_req;
  logic [W-1:0] product, seq_a, seq_b;
  logic [3:0]   seq_ctrl;
  logic [W-1:0] core_a, core_b, alu_in_a, alu_in_b, alu_res;
  logic [3:0]   core_ctrl, alu_in_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .alu_req(alu_req),
    .alu_a(seq_a), .alu_b(seq_b), .alu_ctrl(seq_ctrl), .alu_result(alu_res)
  );

  // Core operands compete for the ALU whenever the sequencer is not requesting it.
  assign alu_in_a    = alu_req ? seq_a    : core_a;
  assign alu_in_b    = alu_req ? seq_b    : core_b;
  assign alu_in_ctrl = alu_req ? seq_ctrl : core_ctrl;

  alu #(.WIDTH(W)) u_alu (
    .a(alu_in_a), .b(alu_in_b), .ctrl(alu_in_ctrl), .result(alu_res)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_runs(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int r = 1;
    for (int i = 0; i < W; i++) if (b[i]) r = i + 1;
    return r;
`else
    return W;
`endif
  endfunction

  // Called at the negedge right after the accepting edge; cyc ends at runs+1 when done shows.
  task automatic wait_done(output int cyc, output int busy_n, output bit req_ok);
    cyc = 1; busy_n = 0; req_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busy_n++;
      if (alu_req !== busy) req_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, bn, r;
    bit ok;
    logic [W-1:0] ref_p;
    ref_p = a * b;
    r = exp_runs(b);
    @(negedge clk); op_a = a; op_b = b; start = 1'b1;
    @(negedge clk); start = 1'b0; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    wait_done(cyc, bn, ok);
    chk({tag, "_lat"},  64'(cyc), 64'(r + 1));
    chk({tag, "_busy"}, 64'(bn),  64'(r));
    chk({tag, "_req"},  64'(ok),  64'(1));
    chk({tag, "_ctrl"}, 64'(seq_ctrl), 64'(ADD));
    chk({tag, "_prod"}, product, ref_p);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'(0));
    chk({tag, "_hold"},  product, ref_p);
  endtask

  initial begin
    int cyc, bn, r, dones;
    bit ok;
    logic [W-1:0] a, b, ones;

    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    core_a = 64'h1234; core_b = 64'h00FF; core_ctrl = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_req",  64'(alu_req), 64'(0));
    chk("rst_prod", product, 64'(0));
    chk("rst_ctrl", 64'(seq_ctrl), 64'b0010);
    chk("core_mux", alu_res, 64'h0034);
    reset = 1'b0;
    @(negedge clk);

    run_mul("m3x5", 64'd3, 64'd5);
    run_mul("ovf", 64'h8000_0000_0000_0000, 64'd2);
    ones = '1;
    run_mul("ones", ones, ones);
    run_mul("b1", 64'hDEAD_BEEF_0000_1111, 64'd1);
    run_mul("b0", 64'hDEAD_BEEF_0000_1111, 64'd0);

    // start re-asserted with new operands during RUN is ignored
    a = 64'd123456789; b = 64'hF000_0000_0000_0001;
    @(negedge clk); op_a = a; op_b = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; dones = 0;
    while (done !== 1'b1 && cyc < 200) begin
      start = (cyc >= 5 && cyc <= 7);
      if (start) begin op_a = 64'd99; op_b = 64'd77; end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    chk("midstart_lat",  64'(cyc), 64'(exp_runs(b) + 1));
    chk("midstart_prod", product, a * b);
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("midstart_dones", 64'(dones), 64'(0));

    // async reset at RUN cycle 30 aborts silently
    @(negedge clk); op_a = 64'd11; op_b = 64'h8000_0000_0000_0003; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (29) @(negedge clk);
    chk("abort_pre_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_req",  64'(alu_req), 64'(0));
    chk("abort_prod", product, 64'(0));
    @(negedge clk); reset = 1'b0;
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_dones", 64'(dones), 64'(0));
    run_mul("post_abort", 64'd1000, 64'd1001);

    // start held through DONE: back-to-back acceptance
    @(negedge clk); op_a = 64'd3; op_b = 64'd5; start = 1'b1;
    @(negedge clk); op_a = 64'd7; op_b = 64'd6;
    wait_done(cyc, bn, ok);
    chk("b2b_lat1",  64'(cyc), 64'(exp_runs(64'd5) + 1));
    chk("b2b_prod1", product, 64'd15);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_pulse", 64'(done), 64'(0));
    chk("b2b_busy",  64'(busy), 64'(1));
    chk("b2b_keep",  product, 64'd15);
    wait_done(cyc, bn, ok);
    chk("b2b_lat2",  64'(cyc), 64'(exp_runs(64'd6) + 1));
    chk("b2b_prod2", product, 64'd42);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      core_a = {$urandom, $urandom}; core_b = {$urandom, $urandom};
      core_ctrl = 4'($urandom_range(7, 0));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(63, 0);
      run_mul($sformatf("rnd%0d", i), a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
